// File: rtl/hwce_shift_adder_pkg.sv
// Shared types, width helpers and saturation constants for the HWCE shift-adder pipeline.
package hwce_shift_adder_pkg;

    // Widest runtime shift amount and bias constant a beat config can carry
    localparam int QF_MAX_WIDTH    = 8;
    localparam int CONST_MAX_WIDTH = 32;

    // Width of one sum-of-products operand
    function automatic int mulWidth(input int convWidth, input int nbMuls);
        return 2 * convWidth + $clog2(nbMuls);
    endfunction

    // Internal sum width: room for N_COL SOP operands plus the shifted bias, plus a sign guard
    function automatic int sumWidth(input int mulW, input int nCol);
        return mulW + $clog2(nCol + 1) + 1;
    endfunction

    // Number of leaves of an adder tree after padding the operand count to a power of two
    function automatic int treeLeaves(input int nOps);
        return 1 << $clog2(nOps);
    endfunction

    // Largest positive value representable in a signed w-bit result
    function automatic logic [CONST_MAX_WIDTH-1:0] satPos(input int w);
        return (CONST_MAX_WIDTH'(1) << (w - 1)) - CONST_MAX_WIDTH'(1);
    endfunction

    // Most negative value representable in a signed w-bit result
    function automatic logic [CONST_MAX_WIDTH-1:0] satNeg(input int w);
        return CONST_MAX_WIDTH'(1) << (w - 1);
    endfunction

    // Per-beat configuration captured at accept and carried alongside the data
    typedef struct packed {
        logic [QF_MAX_WIDTH-1:0]           qf;
        logic                              roundEn;
        logic                              relu;
        logic                              useConst;
        logic signed [CONST_MAX_WIDTH-1:0] constVal;
    } beat_cfg_t;

endpackage

// File: rtl/hwce_adder_tree.sv
// Combinational balanced adder tree; operand count is padded with zeros up to a power of two.
module hwce_adder_tree
    import hwce_shift_adder_pkg::*;
#(
    parameter int N_OPS = 5,
    parameter int WIDTH = 41
) (
    input  logic [N_OPS*WIDTH-1:0] i_operands,
    output logic [WIDTH-1:0]       o_sum
);

    localparam int LEAVES = treeLeaves(N_OPS);

    logic [WIDTH-1:0] w_node [LEAVES];

    // Load the leaves, then fold pairwise level by level; two's complement wrap is harmless
    // because WIDTH already has headroom for the full operand count
    always_comb begin
        for (int i = 0; i < LEAVES; i++) begin
            if (i < N_OPS) begin
                w_node[i] = i_operands[i*WIDTH +: WIDTH];
            end else begin
                w_node[i] = '0;
            end
        end
        for (int span = LEAVES / 2; span >= 1; span = span / 2) begin
            for (int i = 0; i < span; i++) begin
                w_node[i] = w_node[2*i] + w_node[2*i+1];
            end
        end
        o_sum = w_node[0];
    end

endmodule

// File: rtl/hwce_shift_adder_pipe.sv
// Three-stage back-pressurable shift-adder: join bias + SOP columns, add, shift/round,
// saturate, optional ReLU, with a sticky saturation event counter.
// SOP layout: column c, pixel p lives at y_in_sop[(c*NPX+p)*MUL_WIDTH +: MUL_WIDTH].
module hwce_shift_adder_pipe
    import hwce_shift_adder_pkg::*;
#(
    parameter int CONV_WIDTH   = 16,
    parameter int NPX          = 2,
    parameter int NB_MULS      = 25,
    parameter int N_COL        = 4,
    parameter int MUL_WIDTH    = mulWidth(CONV_WIDTH, NB_MULS),
    parameter int SUM_WIDTH    = sumWidth(MUL_WIDTH, N_COL),
    parameter int QF_WIDTH     = 5,
    parameter int SATCNT_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            valid_y_in,
    input  logic [NPX*CONV_WIDTH-1:0]       y_in,
    input  logic [N_COL-1:0]                valid_y_in_sop,
    input  logic [N_COL*NPX*MUL_WIDTH-1:0]  y_in_sop,
    output logic                            ready_in,
    input  logic [QF_WIDTH-1:0]             qf,
    input  logic                            round_en,
    input  logic                            sum_over_constant,
    input  logic [CONV_WIDTH-1:0]           constant_to_sum,
    input  logic                            rectifier_activ,
    output logic [NPX*CONV_WIDTH-1:0]       y_out,
    output logic                            valid_y_out,
    input  logic                            ready_out,
    output logic [SATCNT_WIDTH-1:0]         sat_cnt,
    input  logic                            sat_clr
);

    localparam logic [CONV_WIDTH-1:0] SAT_POS = CONV_WIDTH'(satPos(CONV_WIDTH));
    localparam logic [CONV_WIDTH-1:0] SAT_NEG = CONV_WIDTH'(satNeg(CONV_WIDTH));

    // Stage 1: captured inputs and configuration
    logic                           r_v1;
    logic [NPX*CONV_WIDTH-1:0]      r_yin1;
    logic [N_COL*NPX*MUL_WIDTH-1:0] r_sop1;
    beat_cfg_t                      r_cfg1;

    // Stage 2: adder-tree sums plus the config fields the back end still needs
    logic                           r_v2;
    logic [NPX*SUM_WIDTH-1:0]       r_sum2;
    logic [QF_MAX_WIDTH-1:0]        r_qf2;
    logic                           r_round2;
    logic                           r_relu2;

    // Stage 3: final result and per-pixel saturation flags
    logic                           r_v3;
    logic [NPX*CONV_WIDTH-1:0]      r_y3;
    logic [NPX-1:0]                 r_satMask3;
    logic [SATCNT_WIDTH-1:0]        r_satCnt;

    logic                           w_adv1;
    logic                           w_adv2;
    logic                           w_adv3;
    logic                           w_accept;
    logic                           w_xfer;
    beat_cfg_t                      w_cfgIn;
    logic [NPX*SUM_WIDTH-1:0]       w_sumTree;
    logic [NPX*CONV_WIDTH-1:0]      w_yNext;
    logic [NPX-1:0]                 w_satMask;
    logic [SATCNT_WIDTH:0]          w_satInc;
    logic [SATCNT_WIDTH:0]          w_cntSum;

    // Advance chain: a stage moves when it is empty or its successor moves; ready_in depends
    // only on registered valids and ready_out, never on the incoming valids
    always_comb begin
        w_adv3   = ~r_v3 | ready_out;
        w_adv2   = ~r_v2 | w_adv3;
        w_adv1   = ~r_v1 | w_adv2;
        ready_in = w_adv1;
        w_accept = valid_y_in & (&valid_y_in_sop) & w_adv1;
        w_xfer   = r_v3 & ready_out;
    end

    // Bundle the runtime configuration so it travels with the beat it was sampled for
    always_comb begin
        w_cfgIn          = '0;
        w_cfgIn.qf       = QF_MAX_WIDTH'(qf);
        w_cfgIn.roundEn  = round_en;
        w_cfgIn.relu     = rectifier_activ;
        w_cfgIn.useConst = sum_over_constant;
        w_cfgIn.constVal = CONST_MAX_WIDTH'(signed'(constant_to_sum));
    end

    // Stage 1 register: take a fully joined beat and its configuration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_yin1 <= '0;
            r_sop1 <= '0;
            r_cfg1 <= '0;
        end else if (w_adv1) begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_yin1 <= y_in;
                r_sop1 <= y_in_sop;
                r_cfg1 <= w_cfgIn;
            end
        end
    end

    // Per pixel: pick bias source, pre-shift it into the SOP fixed-point domain, add all columns
    for (genvar p = 0; p < NPX; p++) begin : g_pixAdd
        logic signed [SUM_WIDTH-1:0]   w_base;
        logic signed [SUM_WIDTH-1:0]   w_baseShl;
        logic [(N_COL+1)*SUM_WIDTH-1:0] w_ops;

        // Build the operand vector: shifted bias first, then each sign-extended SOP column
        always_comb begin
            if (r_cfg1.useConst) begin
                w_base = SUM_WIDTH'(signed'(r_cfg1.constVal));
            end else begin
                w_base = SUM_WIDTH'(signed'(r_yin1[p*CONV_WIDTH +: CONV_WIDTH]));
            end
            w_baseShl = w_base <<< r_cfg1.qf;
            w_ops     = '0;
            w_ops[SUM_WIDTH-1:0] = w_baseShl;
            for (int c = 0; c < N_COL; c++) begin
                w_ops[(c+1)*SUM_WIDTH +: SUM_WIDTH] =
                    SUM_WIDTH'(signed'(r_sop1[(c*NPX+p)*MUL_WIDTH +: MUL_WIDTH]));
            end
        end

        hwce_adder_tree #(
            .N_OPS (N_COL + 1),
            .WIDTH (SUM_WIDTH)
        ) u_tree (
            .i_operands (w_ops),
            .o_sum      (w_sumTree[p*SUM_WIDTH +: SUM_WIDTH])
        );
    end

    // Stage 2 register: latch the tree sums and the back-end configuration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2     <= 1'b0;
            r_sum2   <= '0;
            r_qf2    <= '0;
            r_round2 <= 1'b0;
            r_relu2  <= 1'b0;
        end else if (w_adv2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_sum2   <= w_sumTree;
                r_qf2    <= r_cfg1.qf;
                r_round2 <= r_cfg1.roundEn;
                r_relu2  <= r_cfg1.relu;
            end
        end
    end

    // Per pixel: optional round-half-up, arithmetic right shift, saturate, then ReLU
    for (genvar p = 0; p < NPX; p++) begin : g_pixOut
        logic signed [SUM_WIDTH-1:0]   w_sum;
        logic signed [SUM_WIDTH-1:0]   w_rnd;
        logic signed [SUM_WIDTH-1:0]   w_shr;
        logic [SUM_WIDTH-CONV_WIDTH:0] w_top;
        logic                          w_sat;
        logic [CONV_WIDTH-1:0]         w_pix;

        // Saturation is judged on the shifted value, before ReLU, so clipped negatives still count
        always_comb begin
            w_sum = signed'(r_sum2[p*SUM_WIDTH +: SUM_WIDTH]);
            w_rnd = w_sum;
            if (r_round2 && (r_qf2 != '0)) begin
                w_rnd = w_sum + (SUM_WIDTH'(1) << (r_qf2 - QF_MAX_WIDTH'(1)));
            end
            w_shr = w_rnd >>> r_qf2;
            w_top = w_shr[SUM_WIDTH-1:CONV_WIDTH-1];
            w_sat = ~((&w_top) | (~|w_top));
            if (w_sat) begin
                w_pix = w_shr[SUM_WIDTH-1] ? SAT_NEG : SAT_POS;
            end else begin
                w_pix = w_shr[CONV_WIDTH-1:0];
            end
            if (r_relu2 && w_pix[CONV_WIDTH-1]) begin
                w_pix = '0;
            end
        end

        assign w_yNext[p*CONV_WIDTH +: CONV_WIDTH] = w_pix;
        assign w_satMask[p]                        = w_sat;
    end

    // Stage 3 register: the output beat, held stable while downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v3       <= 1'b0;
            r_y3       <= '0;
            r_satMask3 <= '0;
        end else if (w_adv3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_y3       <= w_yNext;
                r_satMask3 <= w_satMask;
            end
        end
    end

    // Count saturated pixels of the beat currently on the output, one bit wider to detect overflow
    always_comb begin
        w_satInc = '0;
        for (int p = 0; p < NPX; p++) begin
            w_satInc = w_satInc + (SATCNT_WIDTH+1)'(r_satMask3[p]);
        end
        w_cntSum = {1'b0, r_satCnt} + w_satInc;
    end

    // Sticky saturation counter; a clear wins over a coincident increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_satCnt <= '0;
        end else if (sat_clr) begin
            r_satCnt <= '0;
        end else if (w_xfer) begin
            r_satCnt <= w_cntSum[SATCNT_WIDTH] ? '1 : w_cntSum[SATCNT_WIDTH-1:0];
        end
    end

    assign y_out       = r_y3;
    assign valid_y_out = r_v3;
    assign sat_cnt     = r_satCnt;

endmodule

// File: tb/tb_hwce_shift_adder_pipe.sv
// Directed testbench for hwce_shift_adder_pipe with the default 16-bit, 2-pixel, 4-column setup.
module tb_hwce_shift_adder_pipe;

   localparam int CW    = 16;
   localparam int NPX   = 2;
   localparam int NCOL  = 4;
   localparam int MUL   = 37;
   localparam int QFW   = 5;
   localparam int SCW   = 16;

   logic                     clock;
   logic                     reset;
   logic                     validYIn;
   logic [NPX*CW-1:0]        yIn;
   logic [NCOL-1:0]          validYInSop;
   logic [NCOL*NPX*MUL-1:0]  yInSop;
   logic                     readyIn;
   logic [QFW-1:0]           qf;
   logic                     roundEn;
   logic                     sumOverConst;
   logic [CW-1:0]            constToSum;
   logic                     relu;
   logic [NPX*CW-1:0]        yOut;
   logic                     validYOut;
   logic                     readyOut;
   logic [SCW-1:0]           satCnt;
   logic                     satClr;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;
   int sent;
   int got;
   int seen;

   hwce_shift_adder_pipe dut (
      .clk               (clock),
      .rst               (reset),
      .valid_y_in        (validYIn),
      .y_in              (yIn),
      .valid_y_in_sop    (validYInSop),
      .y_in_sop          (yInSop),
      .ready_in          (readyIn),
      .qf                (qf),
      .round_en          (roundEn),
      .sum_over_constant (sumOverConst),
      .constant_to_sum   (constToSum),
      .rectifier_activ   (relu),
      .y_out             (yOut),
      .valid_y_out       (validYOut),
      .ready_out         (readyOut),
      .sat_cnt           (satCnt),
      .sat_clr           (satClr)
   );

   // Free-running clock, period 10
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Hard stop in case the sequence ever wedges
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Present a beat: bias pixels b0/b1, SOP column 0 carries s0/s1, other columns zero
   task automatic applyStimulus(input logic [CW-1:0] b0, input logic [CW-1:0] b1,
                                input logic [MUL-1:0] s0, input logic [MUL-1:0] s1);
      yIn                   = {b1, b0};
      yInSop                = '0;
      yInSop[0 +: MUL]      = s0;
      yInSop[MUL +: MUL]    = s1;
      validYIn              = 1'b1;
      validYInSop           = '1;
   endtask

   // Withdraw the input beat
   task automatic idleInputs();
      validYIn    = 1'b0;
      validYInSop = '0;
   endtask

   // Let the presented beat be accepted, then wait (bounded) for it on the output and check it
   task automatic runBeat(input string tag, input logic [NPX*CW-1:0] expY);
      @(negedge clock);
      idleInputs();
      for (int i = 0; i < 8 && !validYOut; i++) @(negedge clock);
      if (!validYOut) checkOutput({tag, "_timeout"}, 64'(validYOut), 64'd1);
      else            checkOutput(tag, 64'(yOut), 64'(expY));
      @(negedge clock);
   endtask

   initial begin
      reset        = 1'b1;
      validYIn     = 1'b0;
      yIn          = '0;
      validYInSop  = '0;
      yInSop       = '0;
      qf           = '0;
      roundEn      = 1'b0;
      sumOverConst = 1'b0;
      constToSum   = '0;
      relu         = 1'b0;
      readyOut     = 1'b1;
      satClr       = 1'b0;

      // Reset state
      repeat (2) @(negedge clock);
      checkOutput("rst_valid", 64'(validYOut), 64'd0);
      checkOutput("rst_yout", 64'(yOut), 64'd0);
      checkOutput("rst_satcnt", 64'(satCnt), 64'd0);
      checkOutput("rst_ready", 64'(readyIn), 64'd1);
      reset = 1'b0;

      // Latency: bias 1 << 13 plus 4 * 0x800, shifted by 13 -> 2 per pixel, exactly 3 edges
      @(negedge clock);
      qf          = 5'd13;
      yIn         = {16'd1, 16'd1};
      for (int c = 0; c < NCOL; c++)
         for (int p = 0; p < NPX; p++)
            yInSop[(c*NPX+p)*MUL +: MUL] = 37'h800;
      validYIn    = 1'b1;
      validYInSop = '1;
      @(negedge clock);
      idleInputs();
      checkOutput("lat_edge1", 64'(validYOut), 64'd0);
      @(negedge clock);
      checkOutput("lat_edge2", 64'(validYOut), 64'd0);
      @(negedge clock);
      checkOutput("lat_edge3", 64'(validYOut), 64'd1);
      checkOutput("lat_value", 64'(yOut), 64'h0002_0002);
      @(negedge clock);
      checkOutput("lat_drain", 64'(validYOut), 64'd0);

      // Rounding: 6/4 -> 2 and -6/4 -> -1 with rounding, 1 and -2 without
      qf = 5'd2; roundEn = 1'b1;
      applyStimulus(16'd0, 16'd0, 37'sd6, -37'sd6);
      runBeat("round_on", 32'hFFFF_0002);
      roundEn = 1'b0;
      applyStimulus(16'd0, 16'd0, 37'sd6, -37'sd6);
      runBeat("round_off", 32'hFFFE_0001);

      // Constant bias -3 replaces y_in: (-6+4)>>1 = -1, (-6+10)>>1 = 2
      qf = 5'd1; sumOverConst = 1'b1; constToSum = 16'hFFFD;
      applyStimulus(16'd100, 16'd100, 37'sd4, 37'sd10);
      runBeat("const_bias", 32'h0002_FFFF);
      sumOverConst = 1'b0;

      // Saturation both ways, then ReLU hides a negative saturation that is still counted
      qf = 5'd0;
      applyStimulus(16'd0, 16'd0, 37'sd40000, -37'sd40000);
      runBeat("sat_pos_neg", 32'h8000_7FFF);
      checkOutput("satcnt_two", 64'(satCnt), 64'd2);
      relu = 1'b1;
      applyStimulus(16'd0, 16'd0, -37'sd40000, 37'sd5);
      runBeat("relu_sat", 32'h0005_0000);
      checkOutput("satcnt_relu", 64'(satCnt), 64'd3);
      relu = 1'b0;

      // Back-pressure: downstream stalled for 5 cycles while 6 beats are offered
      sent = 0;
      got  = 0;
      for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
         @(negedge clock);
         readyOut = (cyc >= 5);
         if (sent < 6) applyStimulus(16'(sent + 1), 16'(sent + 101), 37'd0, 37'd0);
         else          idleInputs();
         #1;
         if (cyc == 3) checkOutput("stall_y_c3", 64'(yOut), 64'h0065_0001);
         if (cyc == 4) begin
            checkOutput("stall_y_c4", 64'(yOut), 64'h0065_0001);
            checkOutput("stall_ready", 64'(readyIn), 64'd0);
            checkOutput("stall_accepted", 64'(sent), 64'd3);
         end
         if (validYOut && readyOut) begin
            checkOutput($sformatf("order_%0d", got), 64'(yOut), {32'd0, 16'(got + 101), 16'(got + 1)});
            got++;
         end
         if (validYIn && readyIn) sent++;
      end
      idleInputs();
      readyOut = 1'b1;
      checkOutput("bp_sent", 64'(sent), 64'd6);
      checkOutput("bp_got", 64'(got), 64'd6);

      // Partial SOP valids must never be accepted
      @(negedge clock);
      applyStimulus(16'd1, 16'd1, 37'sd8, 37'sd8);
      validYInSop = 4'b0111;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (validYOut) seen++;
      end
      idleInputs();
      checkOutput("partial_valid", 64'(seen), 64'd0);

      // qf changes every cycle while beats are in flight; each uses its own qf
      got = 0;
      for (int cyc = 0; cyc < 12 && got < 3; cyc++) begin
         @(negedge clock);
         if (cyc < 3) begin
            qf = 5'(cyc + 1);
            applyStimulus(16'd0, 16'd0, 37'sd8, 37'sd16);
         end else begin
            idleInputs();
            qf = 5'd0;
         end
         #1;
         if (validYOut) begin
            checkOutput($sformatf("qf_flight_%0d", got), 64'(yOut),
                        {32'd0, 16'(16 >> (got + 1)), 16'(8 >> (got + 1))});
            got++;
         end
      end
      idleInputs();
      checkOutput("qf_flight_cnt", 64'(got), 64'd3);

      // Clear coincident with a saturating transfer drops the increment
      @(negedge clock);
      checkOutput("satcnt_pre_clr", 64'(satCnt), 64'd3);
      qf = 5'd0;
      applyStimulus(16'd0, 16'd0, 37'sd40000, 37'sd40000);
      @(negedge clock);
      idleInputs();
      for (int i = 0; i < 8 && !validYOut; i++) @(negedge clock);
      checkOutput("clr_beat", 64'(yOut), 64'h7FFF_7FFF);
      satClr = 1'b1;
      @(negedge clock);
      satClr = 1'b0;
      checkOutput("clr_coincident", 64'(satCnt), 64'd0);
      applyStimulus(16'd0, 16'd0, 37'sd40000, 37'sd5);
      runBeat("post_clr_beat", 32'h0005_7FFF);
      checkOutput("post_clr_cnt", 64'(satCnt), 64'd1);

      // Reset mid-stream: an output is pending and another beat is in flight
      applyStimulus(16'd0, 16'd0, 37'sd1, 37'sd2);
      @(negedge clock);
      applyStimulus(16'd0, 16'd0, 37'sd3, 37'sd4);
      @(negedge clock);
      idleInputs();
      @(negedge clock);
      readyOut = 1'b0;
      #1;
      checkOutput("pre_rst_valid", 64'(validYOut), 64'd1);
      reset = 1'b1;
      #1;
      checkOutput("mid_rst_valid", 64'(validYOut), 64'd0);
      checkOutput("mid_rst_yout", 64'(yOut), 64'd0);
      checkOutput("mid_rst_satcnt", 64'(satCnt), 64'd0);
      @(negedge clock);
      reset    = 1'b0;
      readyOut = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         if (validYOut) seen++;
      end
      checkOutput("no_stale_beats", 64'(seen), 64'd0);
      qf = 5'd2; roundEn = 1'b0;
      applyStimulus(16'd0, 16'd0, 37'sd12, -37'sd12);
      runBeat("post_rst_beat", 32'hFFFD_0003);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
